// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI message assembler.
// Optional channel filter is enabled by defining MIDI_CH_FILTER_EN.
package midi_pkg;

    typedef struct packed {
        logic [7:0] status;
        logic [6:0] d1;
        logic [6:0] d2;
    } msg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_D1,
        S_WAIT_D2,
        S_SYSEX,
        S_DISCARD
    } state_e;

    localparam logic [7:0] ST_NOTE_OFF = 8'h80;
    localparam logic [7:0] ST_NOTE_ON  = 8'h90;
    localparam logic [7:0] ST_PROG     = 8'hC0;
    localparam logic [7:0] ST_CHPRESS  = 8'hD0;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] RT_BASE     = 8'hF8;

    function automatic logic is_one_data(input logic [7:0] status);
        return (status[7:4] == ST_PROG[7:4]) ||
               (status[7:4] == ST_CHPRESS[7:4]);
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// Show-ahead message FIFO with same-cycle read/write and drop reporting.
// Pointers carry one extra wrap bit to tell full from empty.
module midi_msg_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_i,
    input  msg_t wdata_i,
    input  logic rd_i,
    output msg_t head_o,
    output logic empty_o,
    output logic full_o,
    output logic drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wp_q;
    logic [AW:0] rp_q;
    msg_t        mem_q [DEPTH];
    logic        we;
    logic        re;

    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign re      = rd_i & ~empty_o;
    // A pop in the same cycle frees the slot the write needs.
    assign we      = wr_i & (~full_o | re);
    assign drop_o  = wr_i & full_o & ~re;
    assign head_o  = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we) begin
                mem_q[wp_q[AW-1:0]] <= wdata_i;
                wp_q <= wp_q + PTR_ONE;
            end
            if (re) begin
                rp_q <= rp_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/midi_msg_assembler.sv
// MIDI byte stream to channel-voice message assembler with running status.
// Define MIDI_CH_FILTER_EN to add the ch_omni/ch_sel receive-channel filter.
module midi_msg_assembler
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       reg_clk,
    input  logic       reset,
    input  logic       byteready,
    input  logic [7:0] midi_in_data,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       overflow,
    input  logic       overflow_clr
`ifdef MIDI_CH_FILTER_EN
    ,
    input  logic       ch_omni,
    input  logic [3:0] ch_sel
`endif
);

    logic       br_q;
    state_e     state_q, state_d;
    logic [7:0] rs_q, rs_d;
    logic [6:0] d1_q, d1_d;
    logic       emit_q, emit_d;
    msg_t       emsg_q, emsg_d;
    logic       rt_v_q, rt_v_d;
    logic [7:0] rt_b_q, rt_b_d;
    logic       ovf_q;

    logic       ev;
    logic       is_rt, is_sx, is_sc, is_ch;
    logic       ch_ok;
    logic [7:0] st2;
    msg_t       head;
    logic       empty, full, drop;

    assign ev    = byteready & ~br_q;
    assign is_rt = (midi_in_data >= RT_BASE);
    assign is_sx = (midi_in_data == SYSEX_START);
    assign is_ch = midi_in_data[7] & (midi_in_data[7:4] != 4'hF);
    assign is_sc = (midi_in_data[7:4] == 4'hF) & ~is_rt & ~is_sx;

`ifdef MIDI_CH_FILTER_EN
    assign ch_ok = ch_omni | (rs_q[3:0] == ch_sel);
`else
    assign ch_ok = 1'b1;
`endif

    // Note-on with zero velocity is reported as a note-off.
    assign st2 = ((rs_q[7:4] == ST_NOTE_ON[7:4]) &&
                  (midi_in_data[6:0] == 7'd0)) ?
                 {ST_NOTE_OFF[7:4], rs_q[3:0]} : rs_q;

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        d1_d    = d1_q;
        emit_d  = 1'b0;
        emsg_d  = emsg_q;
        rt_v_d  = 1'b0;
        rt_b_d  = rt_b_q;
        if (ev) begin
            unique case (1'b1)
                is_rt: begin
                    rt_v_d = 1'b1;
                    rt_b_d = midi_in_data;
                end
                is_ch: begin
                    rs_d    = midi_in_data;
                    state_d = S_WAIT_D1;
                end
                is_sx: begin
                    rs_d    = 8'h00;
                    state_d = S_SYSEX;
                end
                is_sc: begin
                    rs_d    = 8'h00;
                    state_d = S_DISCARD;
                end
                default: begin
                    case (state_q)
                        S_WAIT_D1: begin
                            d1_d = midi_in_data[6:0];
                            if (is_one_data(rs_q)) begin
                                emit_d = ch_ok;
                                emsg_d = '{rs_q, midi_in_data[6:0], 7'd0};
                            end else begin
                                state_d = S_WAIT_D2;
                            end
                        end
                        S_WAIT_D2: begin
                            emit_d  = ch_ok;
                            emsg_d  = '{st2, d1_q, midi_in_data[6:0]};
                            state_d = S_WAIT_D1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge reg_clk or posedge reset) begin
        if (reset) begin
            br_q    <= 1'b1;
            state_q <= S_IDLE;
            rs_q    <= 8'h00;
            d1_q    <= 7'd0;
            emit_q  <= 1'b0;
            emsg_q  <= '0;
            rt_v_q  <= 1'b0;
            rt_b_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            br_q    <= byteready;
            state_q <= state_d;
            rs_q    <= rs_d;
            d1_q    <= d1_d;
            emit_q  <= emit_d;
            emsg_q  <= emsg_d;
            rt_v_q  <= rt_v_d;
            rt_b_q  <= rt_b_d;
            if (overflow_clr) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    midi_msg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (reg_clk),
        .rst     (reset),
        .wr_i    (emit_q),
        .wdata_i (emsg_q),
        .rd_i    (msg_ready),
        .head_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .drop_o  (drop)
    );

    assign msg_valid  = ~empty;
    assign msg_status = head.status;
    assign msg_data1  = head.d1;
    assign msg_data2  = head.d2;
    assign rt_valid   = rt_v_q;
    assign rt_byte    = rt_b_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Bench for midi_msg_assembler: vector table, hand-written corner cases
// and a randomized byte stream checked against a message-level model.
module tb_midi_msg_assembler;

    logic       reg_clk = 1'b0;
    logic       reset = 1'b1;
    logic       byteready = 1'b0;
    logic [7:0] midi_in_data = 8'h00;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    logic man_ready = 1'b0;
    logic rnd_ready = 1'b0;
    logic mon_on = 1'b0;
    int   errors = 0;
    int   checks = 0;

    assign msg_ready = mon_on ? rnd_ready : man_ready;

    always #5 reg_clk = ~reg_clk;

    midi_msg_assembler #(.FIFO_DEPTH(4)) dut (
        .reg_clk      (reg_clk),
        .reset        (reset),
        .byteready    (byteready),
        .midi_in_data (midi_in_data),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_status   (msg_status),
        .msg_data1    (msg_data1),
        .msg_data2    (msg_data2),
        .rt_valid     (rt_valid),
        .rt_byte      (rt_byte),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    typedef struct packed {
        logic [3:0]  nb;
        logic [55:0] by;
        logic [1:0]  nm;
        logic [65:0] ms;
    } vec_t;

    vec_t tbl [7];

    // Message-level reference: running status plus a list of pending data bytes.
    logic [7:0]  m_rs = 8'h00;
    logic [6:0]  m_dat [$];
    logic [21:0] expq [$];
    logic [7:0]  rtq [$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic void model(input logic [7:0] b);
        logic [7:0] st;
        logic [6:0] d2;
        int need;
        if (b >= 8'hF8) begin
            rtq.push_back(b);
        end else if (b >= 8'hF0) begin
            m_rs = 8'h00;
            m_dat.delete();
        end else if (b >= 8'h80) begin
            m_rs = b;
            m_dat.delete();
        end else if (m_rs != 8'h00) begin
            m_dat.push_back(b[6:0]);
            need = (m_rs >= 8'hC0 && m_rs < 8'hE0) ? 1 : 2;
            if (m_dat.size() == need) begin
                st = m_rs;
                d2 = (need == 2) ? m_dat[1] : 7'd0;
                if (m_rs[7:4] == 4'h9 && need == 2 && d2 == 7'd0)
                    st = m_rs - 8'h10;
                expq.push_back({st, m_dat[0], d2});
                m_dat.delete();
            end
        end
    endfunction

    always @(negedge reg_clk) begin
        if (mon_on) begin
            rnd_ready = ($urandom_range(0, 3) != 0);
            if (msg_valid && rnd_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra: got %0h expected none",
                             {msg_status, msg_data1, msg_data2});
                end else begin
                    chk("rand_msg", {10'h0, msg_status, msg_data1, msg_data2},
                        {10'h0, expq.pop_front()});
                end
            end
            if (rt_valid) begin
                if (rtq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_rt_extra: got %0h expected none", rt_byte);
                end else begin
                    chk("rand_rt", {24'h0, rt_byte}, {24'h0, rtq.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge reg_clk);
        byteready = 1'b1;
        midi_in_data = b;
        @(negedge reg_clk);
        byteready = 1'b0;
        @(negedge reg_clk);
        @(negedge reg_clk);
    endtask

    task automatic do_reset();
        @(negedge reg_clk);
        reset = 1'b1;
        man_ready = 1'b0;
        byteready = 1'b0;
        @(negedge reg_clk);
        reset = 1'b0;
    endtask

    task automatic pop_chk(input string n, input logic [21:0] e);
        chk({n, "_v"}, {31'h0, msg_valid}, 32'h1);
        chk(n, {10'h0, msg_status, msg_data1, msg_data2}, {10'h0, e});
        man_ready = 1'b1;
        @(negedge reg_clk);
        man_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{nb: 4'd3, by: {8'h90, 8'h3C, 8'h64, 32'h0}, nm: 2'd1,
                   ms: {8'h90, 7'h3C, 7'h64, 44'h0}};
        tbl[1] = '{nb: 4'd7,
                   by: {8'h90, 8'h3C, 8'h64, 8'h40, 8'h00, 8'h3C, 8'h10},
                   nm: 2'd3,
                   ms: {8'h90, 7'h3C, 7'h64, 8'h80, 7'h40, 7'h00,
                        8'h90, 7'h3C, 7'h10}};
        tbl[2] = '{nb: 4'd4, by: {8'hB0, 8'h07, 8'hF8, 8'h7F, 24'h0}, nm: 2'd1,
                   ms: {8'hB0, 7'h07, 7'h7F, 44'h0}};
        tbl[3] = '{nb: 4'd5, by: {8'hF0, 8'h41, 8'h10, 8'hF7, 8'h45, 16'h0},
                   nm: 2'd0, ms: 66'h0};
        tbl[4] = '{nb: 4'd3, by: {8'hC2, 8'h05, 8'h06, 32'h0}, nm: 2'd2,
                   ms: {8'hC2, 7'h05, 7'h00, 8'hC2, 7'h06, 7'h00, 22'h0}};
        tbl[5] = '{nb: 4'd5, by: {8'h90, 8'h3C, 8'h80, 8'h40, 8'h00, 16'h0},
                   nm: 2'd1, ms: {8'h80, 7'h40, 7'h00, 44'h0}};
        tbl[6] = '{nb: 4'd5, by: {8'h45, 8'h3C, 8'hE1, 8'h01, 8'h02, 16'h0},
                   nm: 2'd1, ms: {8'hE1, 7'h01, 7'h02, 44'h0}};

        repeat (2) @(negedge reg_clk);
        reset = 1'b0;

        for (int t = 0; t < 7; t++) begin
            do_reset();
            for (int i = 0; i < int'(tbl[t].nb); i++)
                send(tbl[t].by[55-8*i -: 8]);
            for (int k = 0; k < int'(tbl[t].nm); k++)
                pop_chk($sformatf("vec%0d_m%0d", t, k), tbl[t].ms[65-22*k -: 22]);
            chk($sformatf("vec%0d_empty", t), {31'h0, msg_valid}, 32'h0);
        end

        // Reset state, emit latency and real-time pulse.
        do_reset();
        chk("rst_valid", {31'h0, msg_valid}, 32'h0);
        chk("rst_rt", {23'h0, rt_valid, rt_byte}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_head", {10'h0, msg_status, msg_data1, msg_data2}, 32'h0);
        send(8'h90);
        send(8'h3C);
        @(negedge reg_clk);
        byteready = 1'b1;
        midi_in_data = 8'h64;
        @(posedge reg_clk);
        #1 chk("lat_p0", {31'h0, msg_valid}, 32'h0);
        @(posedge reg_clk);
        #1 chk("lat_p1", {31'h0, msg_valid}, 32'h1);
        @(negedge reg_clk);
        byteready = 1'b0;
        @(negedge reg_clk);
        byteready = 1'b1;
        midi_in_data = 8'hF8;
        @(posedge reg_clk);
        #1 chk("rt_pulse", {23'h0, rt_valid, rt_byte}, {23'h0, 1'b1, 8'hF8});
        @(posedge reg_clk);
        #1 chk("rt_end", {23'h0, rt_valid, rt_byte}, {23'h0, 1'b0, 8'hF8});
        @(negedge reg_clk);
        byteready = 1'b0;
        @(negedge reg_clk);
        pop_chk("lat_msg", {8'h90, 7'h3C, 7'h64});
        chk("lat_empty", {31'h0, msg_valid}, 32'h0);

        // Overflow: five CC messages into a four-entry FIFO.
        do_reset();
        send(8'hB0);
        for (int n = 1; n <= 5; n++) begin
            send(8'(n));
            send(8'(n * 16));
        end
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        for (int n = 1; n <= 4; n++)
            pop_chk($sformatf("ovf_m%0d", n), {8'hB0, 7'(n), 7'(n * 16)});
        chk("ovf_empty", {31'h0, msg_valid}, 32'h0);
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);
        overflow_clr = 1'b1;
        @(negedge reg_clk);
        overflow_clr = 1'b0;
        chk("ovf_clr", {31'h0, overflow}, 32'h0);

        // Write on full with a same-cycle pop is accepted.
        do_reset();
        send(8'hB0);
        for (int n = 1; n <= 4; n++) begin
            send(8'(n));
            send(8'(n * 16));
        end
        chk("full_noovf", {31'h0, overflow}, 32'h0);
        send(8'h05);
        @(negedge reg_clk);
        byteready = 1'b1;
        midi_in_data = 8'h50;
        @(negedge reg_clk);
        byteready = 1'b0;
        man_ready = 1'b1;
        @(negedge reg_clk);
        man_ready = 1'b0;
        @(negedge reg_clk);
        chk("sim_noovf", {31'h0, overflow}, 32'h0);
        for (int n = 2; n <= 5; n++)
            pop_chk($sformatf("sim_m%0d", n), {8'hB0, 7'(n), 7'(n * 16)});
        chk("sim_empty", {31'h0, msg_valid}, 32'h0);

        // Reset in the middle of a message.
        do_reset();
        send(8'h90);
        send(8'h3C);
        do_reset();
        chk("midrst_valid", {31'h0, msg_valid}, 32'h0);
        send(8'h64);
        chk("midrst_ign", {31'h0, msg_valid}, 32'h0);

        // Level-held byteready gives a single event.
        do_reset();
        send(8'hC0);
        @(negedge reg_clk);
        byteready = 1'b1;
        midi_in_data = 8'h05;
        repeat (5) @(negedge reg_clk);
        byteready = 1'b0;
        repeat (2) @(negedge reg_clk);
        pop_chk("held_m", {8'hC0, 7'h05, 7'h00});
        chk("held_once", {31'h0, msg_valid}, 32'h0);

        // Randomized stream against the reference model.
        do_reset();
        m_rs = 8'h00;
        m_dat.delete();
        expq.delete();
        rtq.delete();
        mon_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 60)      b = 8'($urandom_range(8'h00, 8'h7F));
            else if (r < 85) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 92) b = 8'($urandom_range(8'hF8, 8'hFF));
            else             b = 8'($urandom_range(8'hF0, 8'hF7));
            model(b);
            send(b);
        end
        repeat (30) @(negedge reg_clk);
        mon_on = 1'b0;
        chk("rand_drain", expq.size(), 0);
        chk("rand_rt_drain", rtq.size(), 0);
        chk("rand_noovf", {31'h0, overflow}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/midi_msg_assembler.md
Name: midi_msg_assembler

Overview:
- Sits directly downstream of the MIDI UART receiver in synth_controller.
- Consumes the raw received byte stream and applies its own running-status tracking.
- Separates real-time bytes onto their own pulse output and discards SysEx and system-common traffic.
- Assembles complete channel-voice messages (status + 1/2 data bytes) into a small FIFO, read by the voice/CC dispatcher through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4: message FIFO entries; power of 2, range 2..16.

Ports:
- reg_clk  in  1  system register clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- byteready  in  1  byte-received strobe from the UART; rising edge is significant.
- midi_in_data  in  8  received byte; valid in the cycle byteready rises.
- msg_valid  out  1  FIFO head holds a message.
- msg_ready  in  1  consumer accepts the head when msg_valid && msg_ready.
- msg_status  out  8  head status byte (type + channel).
- msg_data1  out  7  head first data byte.
- msg_data2  out  7  head second data byte; 0 for one-data-byte messages.
- rt_valid  out  1  one-cycle pulse on a real-time byte.
- rt_byte  out  8  last real-time byte (F8..FF); held between pulses.
- overflow  out  1  sticky flag: a message was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset is asynchronous. On reset:
  - all outputs = 0; FIFO empty; running status = 0; state = IDLE.
  - byteready edge detector register = 1, so a high byteready at reset release is not taken as an edge.
- Byte event: a rising edge of byteready, detected with one reg_clk register. midi_in_data is captured in the edge cycle. A level held high yields exactly one event.
- Classification per byte event:
  - F8..FF (real-time): rt_byte <= byte, rt_valid pulses 1 cycle in the cycle after the event. No state or running-status change.
  - 80..EF (channel status): running status <= byte; state <= WAIT_D1.
  - F0 (SysEx start): running status <= 0; state <= SYSEX.
  - F1..F7 (system common / SysEx end): running status <= 0; state <= DISCARD.
  - 00..7F (data byte): handled by the state machine below.
- State machine (states IDLE, WAIT_D1, WAIT_D2, SYSEX, DISCARD):
  - IDLE / SYSEX / DISCARD + data byte: byte ignored, state unchanged.
  - WAIT_D1 + data: d1 <= byte.
    - Status type Cx or Dx: emit {status, d1, 0}; stay in WAIT_D1 (running status).
    - Otherwise: go to WAIT_D2.
  - WAIT_D2 + data: emit {status, d1, byte}; go to WAIT_D1.
  - A status byte in any state aborts a partial message; the held d1 is discarded.
- Note-on with velocity 0 (9n, d2 = 0) is emitted as status 8n with d2 = 0. Running status stays 9n.
- Emit = FIFO write in the cycle after the byte event.
  - msg_valid rises in the cycle after the write (2 cycles after the byteready edge) when the FIFO was empty.
- FIFO is show-ahead. msg_* reflect the head whenever msg_valid = 1; msg_* are don't-care when msg_valid = 0.
- Full FIFO:
  - Write with no pop in the same cycle: message dropped, overflow <= 1.
  - Write with a pop in the same cycle: write accepted, no overflow.
- Empty FIFO: msg_ready is ignored; no underflow.
- overflow_clr has priority over a simultaneous overflow set; overflow clears to 0.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty and wraps naturally.
- Throughput: at most one byte event per 2 cycles (UART rate is far lower), so there is never more than one emit per cycle.

Optional Feature:
- Macro: MIDI_CH_FILTER_EN.
- When defined:
  - Extra inputs: ch_omni (1) and ch_sel (4).
  - A completed message is written only if ch_omni = 1 or status[3:0] == ch_sel; otherwise it is silently dropped and does not set overflow.
  - Running-status tracking is unaffected by the filter.
- When undefined: ports are absent and every completed message is written.

Decomposition:
- midi_pkg holds:
  - msg_t struct {status[7:0], d1[6:0], d2[6:0]}.
  - state enum.
  - Constants: ST_NOTE_OFF = 8'h80, ST_NOTE_ON = 8'h90, ST_PROG = 8'hC0, ST_CHPRESS = 8'hD0, SYSEX_START = 8'hF0, RT_BASE = 8'hF8.
  - is_one_data(status) function.
- Sub-module midi_msg_fifo: parameterised show-ahead FIFO of msg_t with full/empty, simultaneous read/write and drop-on-full reporting.

Test Plan:
- Bytes 90 3C 64 -> one message {90,3C,64}; msg_valid rises 2 cycles after the edge of byte 64.
- Running status: 90 3C 64 40 00 -> {90,3C,64} then {80,40,00}; a following 3C 10 -> {90,3C,10}.
- Real-time interleave: B0 07 F8 7F -> rt_valid pulse with rt_byte = F8, then one message {B0,07,7F}; FIFO has no F8 entry.
- SysEx and one-data-byte handling:
  - F0 41 10 F7 45 -> no message; 45 is ignored with running status cleared.
  - C2 05 06 -> {C2,05,00} then {C2,06,00}.
- Overflow with FIFO_DEPTH = 4 and msg_ready = 0:
  - Send 5 CC messages: 4 are queued, overflow = 1, and the 5th is lost.
  - A pop in the same cycle as a write on full is accepted without overflow.
  - overflow_clr returns overflow to 0.
- Reset mid-message and level-held byteready:
  - Assert reset after 90 3C: msg_valid = 0 and state = IDLE; a later 64 is ignored.
  - byteready held high for 5 cycles -> exactly 1 byte event.
